// File: rtl/otter_cu_seq.sv
// ============================================================================
//  Module   : otter_cu_seq
//  Purpose  : Multicycle OTTER sequencing control unit with memory wait-state
//             handshakes, wait watchdog, reset hold and registered IR capture.
//             Optional macro OTTER_CU_ILLEGAL_TRAP_EN adds illegal-opcode trap.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_cu_seq #(
    parameter int RST_CYCLES = 2,
    parameter int WAIT_MAX   = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic        intr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        pcWrite,
    output logic        regWrite,
    output logic        memWE2,
    output logic        memRDEN1,
    output logic        memRDEN2,
    output logic        reset,
    output logic        csr_WE,
    output logic        int_taken,
    output logic        mret_exec,
    output logic [3:0]  alu_fun,
    output logic [1:0]  alu_srcA,
    output logic [2:0]  alu_srcB,
    output logic [2:0]  pcSource,
    output logic [1:0]  rf_wr_sel,
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
    output logic        illegal_op,
`endif
    output logic        bus_fault
);

    localparam int CNT_MAX = (RST_CYCLES > WAIT_MAX) ? RST_CYCLES : WAIT_MAX;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] C_RST_LOAD  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] C_WAIT_LOAD = CW'(WAIT_MAX);

    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_IARITH = 7'b0010011;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_SYS    = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_MWAIT,
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
        ST_TRAP,
`endif
        ST_INTR
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    ir_q, ir_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_cond, br_taken;
    logic       unused_ir_bits;

    logic [3:0] dec_fun;
    logic [1:0] dec_srcA;
    logic [2:0] dec_srcB;
    logic [2:0] dec_pcsrc;
    logic [1:0] dec_rfsel;
    logic       dec_wr, dec_csr_we, dec_mret, dec_load, dec_store;
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
    logic       dec_illegal;
`endif

    assign opcode         = ir_q[6:0];
    assign funct3         = ir_q[14:12];
    assign unused_ir_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

    // funct3 = 01x has no comparator condition and is never taken
    always_comb begin
        case (funct3[2:1])
            2'b00:   br_cond = br_eq;
            2'b10:   br_cond = br_lt;
            2'b11:   br_cond = br_ltu;
            default: br_cond = 1'b0;
        endcase
    end
    assign br_taken = (funct3[2:1] != 2'b01) && (br_cond ^ funct3[0]);

    always_comb begin
        dec_fun    = 4'b0000;
        dec_srcA   = 2'd0;
        dec_srcB   = 3'd0;
        dec_pcsrc  = 3'd0;
        dec_rfsel  = 2'd0;
        dec_wr     = 1'b0;
        dec_csr_we = 1'b0;
        dec_mret   = 1'b0;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
        dec_illegal = 1'b0;
`endif
        case (opcode)
            C_OP_RTYPE: begin
                dec_fun   = {ir_q[30], funct3};
                dec_rfsel = 2'd3;
                dec_wr    = 1'b1;
            end
            C_OP_IARITH: begin
                dec_fun   = (funct3 == 3'b101) ? {ir_q[30], funct3} : {1'b0, funct3};
                dec_srcB  = 3'd1;
                dec_rfsel = 2'd3;
                dec_wr    = 1'b1;
            end
            C_OP_LUI: begin
                dec_fun   = 4'b1001;
                dec_srcA  = 2'd1;
                dec_rfsel = 2'd3;
                dec_wr    = 1'b1;
            end
            C_OP_AUIPC: begin
                dec_srcA  = 2'd1;
                dec_srcB  = 3'd3;
                dec_rfsel = 2'd3;
                dec_wr    = 1'b1;
            end
            C_OP_JAL: begin
                dec_pcsrc = 3'd3;
                dec_wr    = 1'b1;
            end
            C_OP_JALR: begin
                dec_pcsrc = 3'd1;
                dec_wr    = 1'b1;
            end
            C_OP_BRANCH: dec_pcsrc = br_taken ? 3'd2 : 3'd0;
            C_OP_LOAD: begin
                dec_srcB = 3'd1;
                dec_load = 1'b1;
            end
            C_OP_STORE: begin
                dec_srcB  = 3'd2;
                dec_store = 1'b1;
            end
            C_OP_SYS: begin
                case (funct3)
                    3'b000: begin
                        dec_pcsrc = 3'd5;
                        dec_mret  = 1'b1;
                    end
                    3'b001: dec_fun = 4'b1001;
                    3'b010: begin
                        dec_srcB = 3'd4;
                        dec_fun  = 4'b0110;
                    end
                    3'b011: begin
                        dec_srcA = 2'd2;
                        dec_srcB = 3'd4;
                        dec_fun  = 4'b0111;
                    end
                    default: ;
                endcase
                if (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec_rfsel  = 2'd1;
                    dec_csr_we = 1'b1;
                    dec_wr     = 1'b1;
                end
            end
            default: begin
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
                dec_illegal = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        memWE2    = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        reset     = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        alu_fun   = 4'b0000;
        alu_srcA  = 2'd0;
        alu_srcB  = 3'd0;
        pcSource  = 3'd0;
        rf_wr_sel = 2'd0;
        bus_fault = 1'b0;
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
        illegal_op = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
                reset = 1'b1;
                if (cnt_q == '0) state_d = ST_FETCH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    memRDEN1 = 1'b1;
                    ir_d     = ir;
                    state_d  = ST_EXEC;
                end else if (cnt_q == '0) begin
                    bus_fault = 1'b1;
                    state_d   = ST_INTR;
                end else begin
                    memRDEN1 = 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                end
            end
            ST_EXEC: begin
                alu_fun  = dec_fun;
                alu_srcA = dec_srcA;
                alu_srcB = dec_srcB;
                pcSource = dec_pcsrc;
                if (dec_load) begin
                    memRDEN2 = 1'b1;
                    state_d  = ST_MWAIT;
                end else if (dec_store) begin
                    memWE2  = 1'b1;
                    state_d = ST_MWAIT;
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
                end else if (dec_illegal) begin
                    illegal_op = 1'b1;
                    state_d    = ST_TRAP;
`endif
                end else begin
                    pcWrite   = 1'b1;
                    regWrite  = dec_wr;
                    rf_wr_sel = dec_rfsel;
                    csr_WE    = dec_csr_we;
                    mret_exec = dec_mret;
                    state_d   = intr ? ST_INTR : ST_FETCH;
                end
            end
            ST_MWAIT: begin
                alu_fun  = dec_fun;
                alu_srcA = dec_srcA;
                alu_srcB = dec_srcB;
                pcSource = dec_pcsrc;
                if (dmem_ready) begin
                    memRDEN2 = dec_load;
                    memWE2   = dec_store;
                    pcWrite  = 1'b1;
                    if (dec_load) begin
                        regWrite  = 1'b1;
                        rf_wr_sel = 2'd2;
                    end
                    state_d = intr ? ST_INTR : ST_FETCH;
                end else if (cnt_q == '0) begin
                    bus_fault = 1'b1;
                    state_d   = ST_INTR;
                end else begin
                    memRDEN2 = dec_load;
                    memWE2   = dec_store;
                    cnt_d    = cnt_q - 1'b1;
                end
            end
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
            ST_TRAP,
`endif
            ST_INTR: begin
                int_taken = 1'b1;
                pcWrite   = 1'b1;
                pcSource  = 3'd4;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_INIT;
        endcase

        if ((state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MWAIT))
            cnt_d = C_WAIT_LOAD;

        // An access in flight when RST arrives is abandoned: nothing commits at that edge
        if (RST) begin
            pcWrite  = 1'b0;
            regWrite = 1'b0;
            memWE2   = 1'b0;
            csr_WE   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            cnt_q   <= C_RST_LOAD;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
        end
    end

endmodule

`default_nettype wire
